// File: rtl/flex_stp_word_rx.sv
// Parametrised serial-to-parallel receiver: shift register with bit counter,
// one-entry word buffer with valid/ready handshake and a sticky overrun flag.
module flex_stp_word_rx #(
  parameter int   NUM_BITS  = 4,
  parameter bit   SHIFT_MSB = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          shift_enable,
  input  logic                          clear,
  output logic [NUM_BITS-1:0]           parallel_out,
  output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
  output logic [NUM_BITS-1:0]           word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          overrun
);

  localparam int CW = $clog2(NUM_BITS+1);
  localparam logic [NUM_BITS-1:0] IDLE_WORD = {NUM_BITS{IDLE_BIT}};
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  typedef enum logic {EMPTY, FULL} buf_state_e;

  buf_state_e          state, state_next;
  logic [NUM_BITS-1:0] sr_next;
  logic [CW-1:0]       count_next;
  logic                complete;
  logic                overrun_next;

  // Shift path: the completed word is the post-shift value, so capture
  // uses sr_next rather than the registered contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sr_next    = parallel_out;
    count_next = bit_count;
    complete   = 1'b0;
    if (clear) begin
      sr_next    = IDLE_WORD;
      count_next = '0;
    end else if (shift_enable) begin
      if (SHIFT_MSB) sr_next = {parallel_out[NUM_BITS-2:0], serial_in};
      else           sr_next = {serial_in, parallel_out[NUM_BITS-1:1]};
      if (bit_count == LAST_BIT) begin
        count_next = '0;
        complete   = 1'b1;
      end else begin
        count_next = bit_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    overrun_next = overrun;
    case (state)
      EMPTY: if (complete) state_next = FULL;
      FULL:  if (word_ready && !complete) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    // A refill racing an accept is not an overrun; only an unconsumed word lost counts.
    if (clear)                                           overrun_next = 1'b0;
    else if (complete && state == FULL && !word_ready)   overrun_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      parallel_out <= IDLE_WORD;
      bit_count    <= '0;
      word_data    <= '0;
      state        <= EMPTY;
      overrun      <= 1'b0;
    end else begin
      parallel_out <= sr_next;
      bit_count    <= count_next;
      state        <= state_next;
      overrun      <= overrun_next;
      if (complete) word_data <= sr_next;
    end
  end

  assign word_valid = (state == FULL);

endmodule

// File: tb/tb_flex_stp_word_rx.sv
// Self-checking bench: two receiver configurations (N=4 LSB-first, N=8 MSB-first)
// compared every cycle against a queue-based model, plus directed literal checks.
module tb_flex_stp_word_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4, LSB-first instance
  logic       si4, se4, clr4, wr4, wv4, ov4;
  logic [3:0] po4, wd4;
  logic [2:0] bc4;
  // N=8, MSB-first instance
  logic       si8, se8, clr8, wr8, wv8, ov8;
  logic [7:0] po8, wd8;
  logic [3:0] bc8;

  flex_stp_word_rx #(.NUM_BITS(4), .SHIFT_MSB(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .serial_in(si4), .shift_enable(se4), .clear(clr4),
    .parallel_out(po4), .bit_count(bc4), .word_data(wd4), .word_valid(wv4),
    .word_ready(wr4), .overrun(ov4));

  flex_stp_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_BIT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .serial_in(si8), .shift_enable(se8), .clear(clr8),
    .parallel_out(po8), .bit_count(bc8), .word_data(wd8), .word_valid(wv8),
    .word_ready(wr8), .overrun(ov8));

  int n_tests = 0;
  int n_fail  = 0;
  bit run_checks = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q holds the bits received since the last clear/reset, newest first.
  bit          q4[$], q8[$];
  int          c4, c8;
  logic        v4, v8, o4, o8;
  logic [31:0] d4, d8;

  function automatic logic [31:0] exp_sr(input int n, input bit msb, input bit q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      bit b;
      b = (i < q.size()) ? q[i] : 1'b1;
      if (msb) v[i] = b;        // newest bit sits at the LSB, older bits above it
      else     v[n-1-i] = b;    // newest bit sits at the MSB, older bits below it
    end
    return v;
  endfunction

  task automatic model_step(input int n, input bit msb, input logic clr, se, si, rdy,
                            inout bit q[$], inout int cnt, inout logic vld,
                            inout logic [31:0] data, inout logic ovr);
    bit done;
    done = 1'b0;
    if (clr) begin
      q.delete();
      cnt = 0;
      ovr = 1'b0;
    end else if (se) begin
      q.push_front(si);
      if (q.size() > n) void'(q.pop_back());
      cnt = cnt + 1;
      if (cnt == n) begin
        cnt  = 0;
        done = 1'b1;
      end
    end
    if (done) begin
      if (vld && !rdy) ovr = 1'b1;
      vld  = 1'b1;
      data = exp_sr(n, msb, q);
    end else if (vld && rdy) begin
      vld = 1'b0;
    end
  endtask

  task automatic model_reset();
    q4.delete(); q8.delete();
    c4 = 0; c8 = 0;
    v4 = 1'b0; v8 = 1'b0; o4 = 1'b0; o8 = 1'b0;
    d4 = '0; d8 = '0;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
  endtask

  // One clock: model advances on the edge from the inputs held across it.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(4, 1'b0, clr4, se4, si4, wr4, q4, c4, v4, d4, o4);
      model_step(8, 1'b1, clr8, se8, si8, wr8, q8, c8, v8, d8, o8);
    end
    #1;
  endtask

  task automatic send4(input bit b);
    si4 = b; se4 = 1'b1; step(); se4 = 1'b0;
  endtask

  task automatic send8(input bit b);
    si8 = b; se8 = 1'b1; step(); se8 = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (run_checks) begin
      check("po4", {28'b0, po4}, exp_sr(4, 1'b0, q4));
      check("bc4", {29'b0, bc4}, c4);
      check("wd4", {28'b0, wd4}, d4);
      check("wv4", {31'b0, wv4}, {31'b0, v4});
      check("ov4", {31'b0, ov4}, {31'b0, o4});
      check("po8", {24'b0, po8}, exp_sr(8, 1'b1, q8));
      check("bc8", {28'b0, bc8}, c8);
      check("wd8", {24'b0, wd8}, d8);
      check("wv8", {31'b0, wv8}, {31'b0, v8});
      check("ov8", {31'b0, ov8}, {31'b0, o8});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_lsb [4];
    logic [3:0] lsb_bits;
    logic [7:0] msb_pat;
    exp_lsb  = '{4'b1111, 4'b0111, 4'b1011, 4'b0101};
    lsb_bits = 4'b0101;   // sent as bit0 first: 1,0,1,0
    msb_pat  = 8'hA5;     // sent MSB first: 1,0,1,0,0,1,0,1

    {si4, se4, clr4, wr4} = '0;
    {si8, se8, clr8, wr8} = '0;
    set_rst(1'b1);
    run_checks = 1'b1;

    // Reset with clocks running and shift requests that must be ignored
    se4 = 1'b1; se8 = 1'b1;
    repeat (3) step();
    check("rst_po4", {28'b0, po4}, 32'hF);
    check("rst_bc4", {29'b0, bc4}, 0);
    check("rst_wv4", {31'b0, wv4}, 0);
    check("rst_ov4", {31'b0, ov4}, 0);
    se4 = 1'b0; se8 = 1'b0;
    set_rst(1'b0);
    step();
    check("post_rst_po4", {28'b0, po4}, 32'hF);
    check("post_rst_po8", {24'b0, po8}, 32'hFF);
    check("post_rst_wv4", {31'b0, wv4}, 0);

    // LSB-first, non-contiguous bits with idle cycles between
    for (int i = 0; i < 4; i++) begin
      send4(lsb_bits[i]);
      check($sformatf("lsb_po_bit%0d", i), {28'b0, po4}, {28'b0, exp_lsb[i]});
      step();
      check($sformatf("lsb_po_idle%0d", i), {28'b0, po4}, {28'b0, exp_lsb[i]});
    end
    check("lsb_wd", {28'b0, wd4}, 32'h5);
    check("lsb_wv", {31'b0, wv4}, 1);
    check("lsb_bc", {29'b0, bc4}, 0);

    // MSB-first N=8, contiguous
    for (int i = 0; i < 8; i++) begin
      si8 = msb_pat[7-i]; se8 = 1'b1; step();
      if (i == 6) check("msb_wv_before", {31'b0, wv8}, 0);
    end
    se8 = 1'b0;
    check("msb_wv_after", {31'b0, wv8}, 1);
    check("msb_wd", {24'b0, wd8}, 32'hA5);
    wr8 = 1'b1; step(); wr8 = 1'b0;
    check("msb_wv_accept", {31'b0, wv8}, 0);

    // Overrun: two words with no consumer
    clr4 = 1'b1; step(); clr4 = 1'b0;
    for (int i = 0; i < 4; i++) send4(1'b0);
    for (int i = 0; i < 4; i++) send4(1'b1);
    check("ovr_wd", {28'b0, wd4}, 32'hF);
    check("ovr_wv", {31'b0, wv4}, 1);
    check("ovr_ov", {31'b0, ov4}, 1);

    // Clear drains the pending word; second word completes with an accept on the same edge
    clr4 = 1'b1; wr4 = 1'b1; step(); clr4 = 1'b0; wr4 = 1'b0;
    check("clr_ov", {31'b0, ov4}, 0);
    check("clr_wv", {31'b0, wv4}, 0);
    for (int i = 0; i < 4; i++) send4(1'b0);
    for (int i = 0; i < 3; i++) send4(1'b1);
    wr4 = 1'b1; send4(1'b1); wr4 = 1'b0;
    check("simul_ov", {31'b0, ov4}, 0);
    check("simul_wv", {31'b0, wv4}, 1);
    check("simul_wd", {28'b0, wd4}, 32'hF);

    // Mid-frame abort via clear, with a shift requested on the same edge
    send4(1'b0); send4(1'b0);
    si4 = 1'b0; se4 = 1'b1; clr4 = 1'b1; step(); se4 = 1'b0; clr4 = 1'b0;
    check("abort_po", {28'b0, po4}, 32'hF);
    check("abort_bc", {29'b0, bc4}, 0);
    for (int i = 0; i < 4; i++) send4(1'b0);
    check("abort_wd", {28'b0, wd4}, 32'h0);

    // Same abort via asynchronous reset, observed before the next edge
    send4(1'b0); send4(1'b0);
    set_rst(1'b1);
    #1;
    check("arst_po", {28'b0, po4}, 32'hF);
    check("arst_bc", {29'b0, bc4}, 0);
    check("arst_wv", {31'b0, wv4}, 0);
    step();
    set_rst(1'b0);
    for (int i = 0; i < 4; i++) send4(1'b0);
    check("arst_wd", {28'b0, wd4}, 32'h0);
    check("arst_po_after", {28'b0, po4}, 32'h0);

    // Randomised traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      si4  = 1'($urandom);       se4  = ($urandom % 4) != 0;
      clr4 = ($urandom % 24) == 0; wr4 = ($urandom % 3) == 0;
      si8  = 1'($urandom);       se8  = ($urandom % 4) != 0;
      clr8 = ($urandom % 40) == 0; wr8 = ($urandom % 5) == 0;
      set_rst(($urandom % 300) == 0);
      step();
    end

    set_rst(1'b0);
    {se4, clr4, wr4, se8, clr8, wr8} = '0;
    step();
    @(negedge clk);
    #1;
    run_checks = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
